// File: rtl/mem_stage_requester.sv
// MEM-stage initiator: turns a one-cycle load/store request into a req/ack
// transaction toward a variable-latency data memory, stalling the pipeline meanwhile.
module mem_stage_requester #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6,
  parameter int          TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       val_rm,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  output logic              freeze,
  output logic [31:0]       res_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              err_range,
  output logic              err_timeout
);

  // state | meaning
  // IDLE  | waiting for a load/store from the pipeline
  // REQ   | bus_req asserted, waiting for bus_ack or timeout
  // DONE  | one-cycle release so the pipeline advances past the finished access
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      off;
  logic [29:0]      word;
  logic [1:0]       unused_lsb;
  logic             in_range;
  logic             req_any;
  logic             timed_out;

  assign off        = alu_res - BASE_ADDR;
  assign word       = off[31:2];
  assign unused_lsb = off[1:0];
  assign in_range   = (alu_res >= BASE_ADDR) && (word < 30'(DEPTH));
  assign req_any    = mem_r_en | mem_w_en;
  assign timed_out  = (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        freeze = req_any;
        if (req_any) state_d = in_range ? REQ : DONE;
      end
      REQ: begin
        freeze = 1'b1;
        if (bus_ack || timed_out) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The request inputs may already be live while reset is held.
    if (!rst) freeze = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      res_data    <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            if (in_range) begin
              bus_req   <= 1'b1;
              bus_addr  <= word[ADDR_W-1:0];
              bus_wdata <= val_rm;
              bus_we    <= mem_w_en;
              wait_cnt  <= '0;
            end else begin
              err_range <= 1'b1;
              res_data  <= '0;
            end
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (bus_ack) begin
            bus_req  <= 1'b0;
            res_data <= bus_we ? 32'd0 : bus_rdata;
          end else if (timed_out) begin
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
            res_data    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_requester.sv
// Bench for mem_stage_requester: random and directed loads/stores against a
// latency-programmable responder, checked by a scoreboard monitor.
module tb_mem_stage_requester;

  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          DEPTH   = 64;
  localparam int          ADDR_W  = 6;
  localparam int          TIMEOUT = 16;
  localparam int          NEVER   = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       alu_res = '0;
  logic [31:0]       val_rm = '0;
  logic              mem_r_en = 1'b0;
  logic              mem_w_en = 1'b0;
  logic              freeze;
  logic [31:0]       res_data;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack = 1'b0;
  logic [31:0]       bus_rdata = '0;
  logic              err_range;
  logic              err_timeout;

  mem_stage_requester #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .alu_res(alu_res), .val_rm(val_rm),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .freeze(freeze),
    .res_data(res_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .err_range(err_range), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                freeze_cyc;
    int                req_cyc;
    bit                uses_bus;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       res;
    logic              erng;
    logic              etmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // responder controls, written only by the stimulus process
  int          resp_lat  = NEVER;
  logic [31:0] resp_data = '0;
  bit          stray_en  = 1'b1;
  bit          force_stray = 1'b0;

  // sticky flag model
  logic erng_acc = 1'b0;
  logic etmo_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Responder: acks on the resp_lat-th cycle that bus_req is seen high.
  int rcyc = 0;
  always @(negedge clk) begin
    if (bus_req) begin
      rcyc++;
      if (rcyc == resp_lat) begin
        bus_ack   = 1'b1;
        bus_rdata = resp_data;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
    end else begin
      rcyc = 0;
      bus_rdata = $urandom;
      bus_ack = force_stray || (stray_en && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: measures each freeze run and checks it when the release cycle appears.
  int                fcnt = 0;
  int                rcnt = 0;
  bit                prev_f = 1'b0;
  logic [31:0]       last_res = '0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic              cap_we = 1'b0;
  logic [31:0]       cap_wd = '0;
  always @(negedge clk) begin
    if (!rst) begin
      fcnt = 0; rcnt = 0; prev_f = 1'b0; last_res = '0;
    end else begin
      if (freeze) begin
        fcnt++;
        chk("res_hold_busy", res_data, last_res);
        if (bus_req) begin
          if (rcnt == 0) begin
            cap_addr = bus_addr; cap_we = bus_we; cap_wd = bus_wdata;
          end else begin
            chk("addr_stable", 32'(bus_addr), 32'(cap_addr));
            chk("wdata_stable", bus_wdata, cap_wd);
          end
          rcnt++;
        end
      end else begin
        chk("req_without_freeze", 32'(bus_req), 32'd0);
        if (prev_f) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("freeze_cycles", 32'(fcnt), 32'(e.freeze_cyc));
            chk("req_cycles", 32'(rcnt), 32'(e.req_cyc));
            if (e.uses_bus) begin
              chk("bus_addr", 32'(cap_addr), 32'(e.addr));
              chk("bus_we", 32'(cap_we), 32'(e.we));
              chk("bus_wdata", cap_wd, e.wdata);
            end
            chk("res_data", res_data, e.res);
            chk("err_range", 32'(err_range), 32'(e.erng));
            chk("err_timeout", 32'(err_timeout), 32'(e.etmo));
            last_res = e.res;
          end
          fcnt = 0; rcnt = 0;
        end else begin
          chk("res_hold_idle", res_data, last_res);
        end
      end
      prev_f = freeze;
    end
  end

  task automatic do_txn(input logic [31:0] addr, input logic r, input logic w,
                        input logic [31:0] d, input int lat, input logic [31:0] rd);
    exp_t e;
    longint off;
    int     word;
    bit     inr;
    int     n;
    off  = longint'(addr) - longint'(BASE);
    inr  = (off >= 0) && (off / 4 < DEPTH);
    word = inr ? int'(off / 4) : 0;
    e.uses_bus = inr;
    e.addr  = word[ADDR_W-1:0];
    e.we    = w;
    e.wdata = d;
    if (!inr) begin
      e.freeze_cyc = 1; e.req_cyc = 0; e.res = 32'd0; erng_acc = 1'b1;
    end else if (lat <= TIMEOUT) begin
      e.freeze_cyc = lat + 1; e.req_cyc = lat; e.res = w ? 32'd0 : rd;
    end else begin
      e.freeze_cyc = TIMEOUT + 1; e.req_cyc = TIMEOUT; e.res = 32'd0; etmo_acc = 1'b1;
    end
    e.erng = erng_acc;
    e.etmo = etmo_acc;
    exp_q.push_back(e);
    resp_lat  = lat;
    resp_data = rd;
    @(posedge clk); #1;
    alu_res = addr; mem_r_en = r; mem_w_en = w; val_rm = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (freeze && n < TIMEOUT + 10);
    if (freeze) begin
      chk("freeze_release_bound", 32'(n), 32'(TIMEOUT + 2));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    // leave the stale request visible through DONE, then maybe idle a bit
    if ($urandom_range(0, 1) == 1) begin
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = $urandom;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)      return BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
    else if (k < 8) return 32'($urandom_range(0, 1023));
    else if (k < 9) return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
    else            return $urandom;
  endfunction

  function automatic int rand_lat();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)      return $urandom_range(1, 5);
    else if (k < 8) return $urandom_range(TIMEOUT - 1, TIMEOUT);
    else            return (k == 8) ? TIMEOUT + 1 : NEVER;
  endfunction

  initial begin
    // reset state, with a request already present on the inputs
    mem_r_en = 1'b1; alu_res = 32'd1032;
    #12;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_errs", {30'd0, err_range, err_timeout}, 32'd0);
    mem_r_en = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    do_txn(32'd1032, 1'b1, 1'b0, 32'h0, 1, 32'hDEADBEEF);
    do_txn(32'd1028, 1'b0, 1'b1, 32'h12345678, 4, 32'hFFFF0000);
    do_txn(32'd1036, 1'b1, 1'b0, 32'h0, TIMEOUT, 32'hCAFE0001);
    do_txn(32'd1040, 1'b1, 1'b0, 32'h0, NEVER, 32'h0);
    do_txn(32'd1044, 1'b1, 1'b1, 32'hA5A5A5A5, 2, 32'h11111111);
    do_txn(32'd1276, 1'b1, 1'b0, 32'h0, 1, 32'h00C0FFEE);
    do_txn(32'd1020, 1'b1, 1'b0, 32'h0, 1, 32'h77777777);
    do_txn(32'd1280, 1'b0, 1'b1, 32'h1, 1, 32'h0);
    do_txn(32'd1048, 1'b1, 1'b0, 32'h0, 3, 32'h13572468);

    // abort mid-REQ with reset
    resp_lat = NEVER;
    @(posedge clk); #1;
    alu_res = 32'd1052; mem_r_en = 1'b1; mem_w_en = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10 && seen < 2; i++) begin
        @(negedge clk);
        if (bus_req) seen++;
      end
      chk("abort_reached_req", 32'(seen), 32'd2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_bus_req", 32'(bus_req), 32'd0);
    chk("abort_freeze", 32'(freeze), 32'd0);
    chk("abort_res_data", res_data, 32'd0);
    chk("abort_errs", {30'd0, err_range, err_timeout}, 32'd0);
    erng_acc = 1'b0; etmo_acc = 1'b0;
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    rst = 1'b1;
    force_stray = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_stray = 1'b0;
    chk("stray_bus_req", 32'(bus_req), 32'd0);
    chk("stray_freeze", 32'(freeze), 32'd0);
    chk("stray_errs", {30'd0, err_range, err_timeout}, 32'd0);
    do_txn(32'd1056, 1'b1, 1'b0, 32'h0, 1, 32'h2468ACE0);

    for (int i = 0; i < 150; i++) begin
      logic r, w;
      int   k;
      k = $urandom_range(0, 3);
      r = (k != 1);
      w = (k != 0);
      do_txn(rand_addr(), r, w, $urandom, rand_lat(), $urandom);
    end

    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
